csc_pixel_serializer: RTL

//  Output-side companion of the colour-space converter: accepts one 3-component pixel per

---
 rtl/csc_pkg.sv | 27 ++
 rtl/csc_pixel_fifo.sv | 58 +++++
 rtl/csc_pixel_serializer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/csc_pkg.sv
// Shared definitions for the colour-space converter output path.
package csc_pkg;

   localparam int unsigned DATA_WIDTH = 8;

   // Colour-space codes carried alongside each pixel
   typedef enum logic [1:0] {
      CS_RGB = 2'b00,
      CS_YUV = 2'b01,
      CS_CMY = 2'b10,
      CS_HSV = 2'b11
   } cs_e;

   // Component index presented on the serial stream
   typedef logic [1:0] comp_idx_t;
   localparam comp_idx_t COMP_0 = 2'd0;
   localparam comp_idx_t COMP_1 = 2'd1;
   localparam comp_idx_t COMP_2 = 2'd2;

   // Serializer FSM encoding
   typedef logic [1:0] ser_state_t;
   localparam ser_state_t ST_IDLE = 2'd0;
   localparam ser_state_t ST_C0   = 2'd1;
   localparam ser_state_t ST_C1   = 2'd2;
   localparam ser_state_t ST_C2   = 2'd3;

endpackage

// File: rtl/csc_pixel_fifo.sv
// Pixel FIFO with first-word-fall-through head and a look-ahead view of the
// entry behind the head, so the serializer can chain pixels without a bubble.
module csc_pixel_fifo #(
   parameter int unsigned WIDTH = 26,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_c,
   output logic [WIDTH-1:0]           next_c,
   output logic                       full_c,
   output logic                       empty_c,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full_c  = (count == CW'(DEPTH));
   assign empty_c = (count == '0);
   assign do_push = push && !full_c && !flush;
   assign do_pop  = pop && !empty_c && !flush;
   assign head_c  = mem[rd_ptr];
   assign next_c  = mem[rd_ptr + AW'(1)];

   // Pointer and occupancy tracking; flush empties the queue
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage array, no reset needed since occupancy gates every read
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/csc_pixel_serializer.sv
// Takes whole pixels from the CSC output register and emits them one
// component per beat, tagging start-of-frame and end-of-line.
module csc_pixel_serializer #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned LINE_WIDTH   = 640,
   parameter int unsigned FRAME_HEIGHT = 480
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic [1:0]            cs_tag,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   input  logic [DATA_WIDTH-1:0] pix_c1,
   input  logic [DATA_WIDTH-1:0] pix_c2,
   input  logic [DATA_WIDTH-1:0] pix_c3,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            out_comp,
   output logic [1:0]            out_cs,
   output logic                  out_sof,
   output logic                  out_eol
);

   import csc_pkg::*;

   localparam int unsigned DW    = DATA_WIDTH;
   localparam int unsigned PIX_W = 3 * DW + 2;
   localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned XW    = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam int unsigned YW    = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

   ser_state_t      state, state_n;
   logic [PIX_W-1:0] head_c, next_c;
   logic            fifo_full_c, fifo_empty_c;
   logic [CW-1:0]   fifo_count;
   logic [CW-1:0]   count_n_c;
   logic            push_c, pop_c, hs_c;

   logic            valid_n;
   logic [DW-1:0]   data_n;
   comp_idx_t       comp_n;
   logic [1:0]      cs_n;
   logic            sof_n, eol_n;
   logic [XW-1:0]   x, x_n;
   logic [YW-1:0]   y, y_n;

   assign push_c    = pix_valid && pix_ready && !fifo_full_c && !flush;
   assign hs_c      = out_valid && out_ready;
   assign count_n_c = flush ? '0 : (fifo_count + CW'(push_c) - CW'(pop_c && !fifo_empty_c));

   csc_pixel_fifo #(
      .WIDTH (PIX_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .push    (push_c),
      .wdata   ({cs_tag, pix_c1, pix_c2, pix_c3}),
      .pop     (pop_c),
      .head_c  (head_c),
      .next_c  (next_c),
      .full_c  (fifo_full_c),
      .empty_c (fifo_empty_c),
      .count   (fifo_count)
   );

   // Next-state, next-output and counter logic for the component sequencer
   always_comb begin
      state_n = state;
      valid_n = out_valid;
      data_n  = out_data;
      comp_n  = out_comp;
      cs_n    = out_cs;
      sof_n   = out_sof;
      eol_n   = out_eol;
      x_n     = x;
      y_n     = y;
      pop_c   = 1'b0;

      if (flush) begin
         state_n = ST_IDLE;
         valid_n = 1'b0;
         data_n  = '0;
         comp_n  = COMP_0;
         cs_n    = '0;
         sof_n   = 1'b0;
         eol_n   = 1'b0;
         x_n     = '0;
         y_n     = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty_c) begin
                  state_n = ST_C0;
                  valid_n = 1'b1;
                  data_n  = head_c[3*DW-1 -: DW];
                  comp_n  = COMP_0;
                  cs_n    = head_c[PIX_W-1 -: 2];
                  sof_n   = (x == '0) && (y == '0);
                  eol_n   = 1'b0;
               end
            end
            ST_C0: begin
               if (hs_c) begin
                  state_n = ST_C1;
                  data_n  = head_c[2*DW-1 -: DW];
                  comp_n  = COMP_1;
                  sof_n   = 1'b0;
                  eol_n   = 1'b0;
               end
            end
            ST_C1: begin
               if (hs_c) begin
                  state_n = ST_C2;
                  data_n  = head_c[DW-1:0];
                  comp_n  = COMP_2;
                  sof_n   = 1'b0;
                  eol_n   = (x == XW'(LINE_WIDTH - 1));
               end
            end
            default: begin
               if (hs_c) begin
                  pop_c = 1'b1;
                  if (x == XW'(LINE_WIDTH - 1)) begin
                     x_n = '0;
                     y_n = (y == YW'(FRAME_HEIGHT - 1)) ? '0 : (y + YW'(1));
                  end else begin
                     x_n = x + XW'(1);
                  end
                  // Chain straight into the entry behind the head when present
                  if (fifo_count > CW'(1)) begin
                     state_n = ST_C0;
                     valid_n = 1'b1;
                     data_n  = next_c[3*DW-1 -: DW];
                     comp_n  = COMP_0;
                     cs_n    = next_c[PIX_W-1 -: 2];
                     sof_n   = (x_n == '0) && (y_n == '0);
                     eol_n   = 1'b0;
                  end else begin
                     state_n = ST_IDLE;
                     valid_n = 1'b0;
                     data_n  = '0;
                     comp_n  = COMP_0;
                     cs_n    = '0;
                     sof_n   = 1'b0;
                     eol_n   = 1'b0;
                  end
               end
            end
         endcase
      end
   end

   // State, output and position registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_comp  <= COMP_0;
         out_cs    <= '0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         x         <= '0;
         y         <= '0;
         pix_ready <= 1'b0;
      end else begin
         state     <= state_n;
         out_valid <= valid_n;
         out_data  <= data_n;
         out_comp  <= comp_n;
         out_cs    <= cs_n;
         out_sof   <= sof_n;
         out_eol   <= eol_n;
         x         <= x_n;
         y         <= y_n;
         pix_ready <= (count_n_c != CW'(FIFO_DEPTH));
      end
   end

endmodule
